kbd_wb_responder: RTL and testbench

Wishbone responder for the PET keyboard matrix. It holds the 10 row registers in the WB_KBD_BASE window (address bits [19:17] = 3'b011). The MCU writes key state over the SPI-to-Wishbone bridge. The emulated PIA port-A row select reads back column data for the CPU.

---
 rtl/kbd_wb_responder.sv | 124 ++++++++++++
 tb/tb_kbd_wb_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_wb_responder.sv
// kbd_wb_responder: Wishbone-mapped PET keyboard row registers with registered PIA column readback.
// Optional feature KBD_AUTO_RELEASE_EN releases all keys after AUTO_RELEASE_SCANS CPU scans without MCU writes.
module kbd_wb_responder #(
  parameter int ROW_COUNT          = 10,
  parameter int ADDR_WIDTH         = 20,
  parameter int DATA_WIDTH         = 8,
  parameter int AUTO_RELEASE_SCANS = 3
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic                  wb_ack_o,
  output logic                  wb_stall_o,
  input  logic [3:0]            pia_row_i,
  output logic [DATA_WIDTH-1:0] pia_col_o
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] rows_q [ROW_COUNT];
  logic [DATA_WIDTH-1:0] rows_d [ROW_COUNT];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] col_q, col_d;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  sel, accept, wr_accept, release_all;
  logic [3:0]            row_idx;
  logic                  unused_addr;

  assign sel         = (wb_addr_i[ADDR_WIDTH-1 -: 3] == 3'b011);
  assign row_idx     = wb_addr_i[3:0];
  assign accept      = wb_cyc_i & wb_stb_i & sel & ~wb_stall_o;
  assign wr_accept   = accept & wb_we_i;
  assign unused_addr = ^wb_addr_i[ADDR_WIDTH-4:4];

  assign wb_stall_o = (state_q == ST_ACK);
  // Dropping cyc mid-ACK kills the ack combinationally; the FSM still returns to IDLE.
  assign wb_ack_o   = (state_q == ST_ACK) & wb_cyc_i;
  assign wb_data_o  = rdata_q;
  assign pia_col_o  = col_q;

`ifdef KBD_AUTO_RELEASE_EN
  localparam int CNT_W = $clog2(AUTO_RELEASE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(AUTO_RELEASE_SCANS);

  logic [3:0]       prev_row_q, prev_row_d;
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic             scan_done;

  assign prev_row_d  = pia_row_i;
  assign scan_done   = (prev_row_q == 4'(ROW_COUNT - 1)) && (pia_row_i == 4'd0);
  assign release_all = (scan_cnt_q == CNT_MAX);

  // Any MCU write proves the link is alive, so it restarts the scan count.
  always_comb begin
    scan_cnt_d = scan_cnt_q;
    if (wr_accept) begin
      scan_cnt_d = '0;
    end else if (scan_done && !release_all) begin
      scan_cnt_d = scan_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      prev_row_q <= 4'd0;
      scan_cnt_q <= '0;
    end else begin
      prev_row_q <= prev_row_d;
      scan_cnt_q <= scan_cnt_d;
    end
  end
`else
  logic unused_cfg;
  assign release_all = 1'b0;
  assign unused_cfg  = AUTO_RELEASE_SCANS[0];
`endif

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    rd_val  = '1;
    col_d   = '1;
    for (int i = 0; i < ROW_COUNT; i++) begin
      rows_d[i] = release_all ? '1 : rows_q[i];
      if (row_idx == 4'(i)) rd_val = rows_q[i];
      if (pia_row_i == 4'(i)) col_d = rows_q[i];
    end
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ACK;
          if (wb_we_i) begin
            for (int i = 0; i < ROW_COUNT; i++) begin
              if (row_idx == 4'(i)) rows_d[i] = wb_data_i;
            end
          end else begin
            rdata_d = rd_val;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
      col_q   <= '1;
      for (int i = 0; i < ROW_COUNT; i++) rows_q[i] <= '1;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      col_q   <= col_d;
      for (int i = 0; i < ROW_COUNT; i++) rows_q[i] <= rows_d[i];
    end
  end
endmodule

// File: tb/tb_kbd_wb_responder.sv
// Self-checking bench for kbd_wb_responder; a row-array model predicts bus reads and PIA columns.
module tb_kbd_wb_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] wb_addr;
  logic [7:0]  wb_wdata, wb_rdata, pia_col;
  logic        wb_we, wb_cyc, wb_stb, wb_ack, wb_stall;
  logic [3:0]  pia_row;

  int tests = 0;
  int fails = 0;
  logic [7:0] model [10];

  always #5 clk = ~clk;

  kbd_wb_responder dut (
    .clock_i(clk), .reset_i(rst),
    .wb_addr_i(wb_addr), .wb_data_i(wb_wdata), .wb_data_o(wb_rdata),
    .wb_we_i(wb_we), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb),
    .wb_ack_o(wb_ack), .wb_stall_o(wb_stall),
    .pia_row_i(pia_row), .pia_col_o(pia_col)
  );

  function automatic logic [7:0] exp_row(input int r);
    return (r < 10) ? model[r] : 8'hFF;
  endfunction

  function automatic void model_write(input int r, input logic [7:0] d);
    if (r < 10) model[r] = d;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 10; i++) model[i] = 8'hFF;
  endfunction

  // One single-beat transaction starting and ending 1 time unit after a rising edge.
  task automatic bus_cycle(input logic we, input logic [19:0] addr, input logic [7:0] wd,
                           output logic ack_pre, output logic ack_seen,
                           output logic stall_seen, output logic [7:0] rd);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = addr; wb_wdata = wd;
    #1 ack_pre = wb_ack;
    @(posedge clk); #1;
    ack_seen = wb_ack; stall_seen = wb_stall; rd = wb_rdata;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic scan_once();
    for (int r = 1; r <= 10; r++) begin
      pia_row = (r == 10) ? 4'd0 : 4'(r);
      step();
    end
  endtask

  task automatic test_reset();
    logic a0, a1, s; logic [7:0] d;
    tests++; if (wb_ack !== 1'b0 || wb_stall !== 1'b0 || wb_rdata !== 8'h00 || pia_col !== 8'hFF) begin
      fails++; $display("FAIL reset_outputs: ack=%b stall=%b data=%h col=%h, required 0 0 00 FF",
                        wb_ack, wb_stall, wb_rdata, pia_col);
    end
    for (int r = 0; r < 10; r++) begin
      bus_cycle(1'b0, 20'h60000 + 20'(r), 8'h00, a0, a1, s, d);
      tests++; if (a0 !== 1'b0 || a1 !== 1'b1) begin
        fails++; $display("FAIL reset_read_latency row %0d: ack before/after accept=%b/%b, required 0/1", r, a0, a1);
      end
      tests++; if (d !== 8'hFF) begin
        fails++; $display("FAIL reset_read_data row %0d: got %h, required FF", r, d);
      end
    end
    for (int r = 0; r < 16; r++) begin
      pia_row = 4'(r); step();
      tests++; if (pia_col !== 8'hFF) begin
        fails++; $display("FAIL reset_pia row %0d: got %h, required FF", r, pia_col);
      end
    end
  endtask

  task automatic test_write_read();
    logic a0, a1, s; logic [7:0] d, old;
    bus_cycle(1'b1, 20'h60003, 8'hFE, a0, a1, s, d); model_write(3, 8'hFE);
    tests++; if (a1 !== 1'b1) begin fails++; $display("FAIL write_ack: got %b, required 1", a1); end
    pia_row = 4'd3; step();
    tests++; if (pia_col !== exp_row(3)) begin
      fails++; $display("FAIL pia_row3: got %h, required %h", pia_col, exp_row(3));
    end
    bus_cycle(1'b0, 20'h60003, 8'h00, a0, a1, s, d);
    tests++; if (d !== exp_row(3)) begin fails++; $display("FAIL read_row3: got %h, required %h", d, exp_row(3)); end
    pia_row = 4'd4; step();
    tests++; if (pia_col !== exp_row(4)) begin
      fails++; $display("FAIL pia_row4: got %h, required %h", pia_col, exp_row(4));
    end
    // Collision: write row 3 while the PIA is selecting it.
    pia_row = 4'd3; step();
    old = exp_row(3);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = 20'h60003; wb_wdata = 8'h55;
    step(); model_write(3, 8'h55);
    tests++; if (pia_col !== old) begin fails++; $display("FAIL collision_old: got %h, required %h", pia_col, old); end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    step();
    tests++; if (pia_col !== 8'h55) begin fails++; $display("FAIL collision_new: got %h, required 55", pia_col); end
    bus_cycle(1'b0, 20'h6FFF3, 8'h00, a0, a1, s, d);
    tests++; if (a1 !== 1'b1 || d !== exp_row(3)) begin
      fails++; $display("FAIL dont_care_bits: ack=%b data=%h, required 1 %h", a1, d, exp_row(3));
    end
  endtask

  task automatic test_discard_unselected();
    logic a0, a1, s; logic [7:0] d;
    bus_cycle(1'b1, 20'h6000C, 8'h00, a0, a1, s, d);
    tests++; if (a1 !== 1'b1) begin fails++; $display("FAIL discard_ack: got %b, required 1", a1); end
    for (int r = 0; r < 10; r++) begin
      bus_cycle(1'b0, 20'h60000 + 20'(r), 8'h00, a0, a1, s, d);
      tests++; if (d !== exp_row(r)) begin
        fails++; $display("FAIL discard_row %0d: got %h, required %h", r, d, exp_row(r));
      end
    end
    bus_cycle(1'b0, 20'h6000C, 8'h00, a0, a1, s, d);
    tests++; if (d !== 8'hFF) begin fails++; $display("FAIL read_row12: got %h, required FF", d); end
    bus_cycle(1'b1, 20'h40003, 8'h00, a0, a1, s, d);
    tests++; if (a1 !== 1'b0 || s !== 1'b0) begin
      fails++; $display("FAIL unselected_40000: ack=%b stall=%b, required 0 0", a1, s);
    end
    bus_cycle(1'b1, 20'hE0003, 8'h00, a0, a1, s, d);
    tests++; if (a1 !== 1'b0 || s !== 1'b0) begin
      fails++; $display("FAIL unselected_E0000: ack=%b stall=%b, required 0 0", a1, s);
    end
    bus_cycle(1'b0, 20'h60003, 8'h00, a0, a1, s, d);
    tests++; if (d !== exp_row(3)) begin
      fails++; $display("FAIL unselected_no_write: got %h, required %h", d, exp_row(3));
    end
  endtask

  task automatic test_back_to_back();
    logic a0, a1, s; logic [7:0] d;
    bus_cycle(1'b1, 20'h60004, 8'h3C, a0, a1, s, d); model_write(4, 8'h3C);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 20'h60003;
    step();
    tests++; if (wb_ack !== 1'b1 || wb_stall !== 1'b1 || wb_rdata !== exp_row(3)) begin
      fails++; $display("FAIL b2b_first: ack=%b stall=%b data=%h, required 1 1 %h", wb_ack, wb_stall, wb_rdata, exp_row(3));
    end
    wb_addr = 20'h60004;
    step();
    tests++; if (wb_ack !== 1'b0 || wb_stall !== 1'b0) begin
      fails++; $display("FAIL b2b_gap: ack=%b stall=%b, required 0 0", wb_ack, wb_stall);
    end
    step();
    tests++; if (wb_ack !== 1'b1 || wb_rdata !== exp_row(4)) begin
      fails++; $display("FAIL b2b_second: ack=%b data=%h, required 1 %h", wb_ack, wb_rdata, exp_row(4));
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    step();
    // Abandon a write during its ACK cycle.
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = 20'h60007; wb_wdata = 8'hAA;
    step(); model_write(7, 8'hAA);
    tests++; if (wb_ack !== 1'b1) begin fails++; $display("FAIL cyc_drop_pre: ack=%b, required 1", wb_ack); end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    #1;
    tests++; if (wb_ack !== 1'b0) begin fails++; $display("FAIL cyc_drop_ack: ack=%b, required 0", wb_ack); end
    step();
    tests++; if (wb_stall !== 1'b0) begin fails++; $display("FAIL cyc_drop_idle: stall=%b, required 0", wb_stall); end
    bus_cycle(1'b0, 20'h60007, 8'h00, a0, a1, s, d);
    tests++; if (a1 !== 1'b1 || d !== exp_row(7)) begin
      fails++; $display("FAIL cyc_drop_commit: ack=%b data=%h, required 1 %h", a1, d, exp_row(7));
    end
  endtask

  task automatic test_random();
    logic a0, a1, s; logic [7:0] d, wd;
    int op, r; logic [3:0] last, nxt; logic [19:0] addr;
    bus_cycle(1'b1, 20'h6000F, 8'h00, a0, a1, s, d);
    last = pia_row;
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 2); r = $urandom_range(0, 15); wd = 8'($urandom);
      nxt = 4'($urandom_range(0, 15));
      if (last == 4'd9 && nxt == 4'd0) nxt = 4'd1;  // keep scan counting out of this test
      pia_row = nxt; last = nxt;
      if (op == 2) begin
        addr = {3'($urandom_range(0, 7)), 13'($urandom), 4'(r)};
        if (addr[19:17] == 3'b011) addr[19] = 1'b1;
      end else begin
        addr = {3'b011, 13'($urandom), 4'(r)};
      end
      bus_cycle(op != 1, addr, wd, a0, a1, s, d);
      if (op == 0) model_write(r, wd);
      tests++; if (a1 !== (op != 2)) begin
        fails++; $display("FAIL rand_ack #%0d: got %b, required %b", n, a1, op != 2);
      end
      if (op == 1) begin
        tests++; if (d !== exp_row(r)) begin
          fails++; $display("FAIL rand_read #%0d row %0d: got %h, required %h", n, r, d, exp_row(r));
        end
      end
      tests++; if (pia_col !== exp_row(int'(nxt))) begin
        fails++; $display("FAIL rand_pia #%0d row %0d: got %h, required %h", n, nxt, pia_col, exp_row(int'(nxt)));
      end
    end
  endtask

`ifdef KBD_AUTO_RELEASE_EN
  task automatic test_auto_release();
    logic a0, a1, s; logic [7:0] d;
    pia_row = 4'd1; step();
    bus_cycle(1'b1, 20'h60005, 8'h7F, a0, a1, s, d); model_write(5, 8'h7F);
    scan_once(); scan_once(); step();
    bus_cycle(1'b0, 20'h60005, 8'h00, a0, a1, s, d);
    tests++; if (d !== 8'h7F) begin fails++; $display("FAIL auto_two_scans: got %h, required 7F", d); end
    scan_once(); step(); model_reset();
    bus_cycle(1'b0, 20'h60005, 8'h00, a0, a1, s, d);
    tests++; if (d !== 8'hFF) begin fails++; $display("FAIL auto_release: got %h, required FF", d); end
    bus_cycle(1'b1, 20'h60005, 8'h7F, a0, a1, s, d); model_write(5, 8'h7F);
    scan_once(); scan_once();
    bus_cycle(1'b1, 20'h6000C, 8'h00, a0, a1, s, d);
    scan_once(); step();
    bus_cycle(1'b0, 20'h60005, 8'h00, a0, a1, s, d);
    tests++; if (d !== 8'h7F) begin fails++; $display("FAIL auto_deferred: got %h, required 7F", d); end
    scan_once(); scan_once(); step(); model_reset();
    bus_cycle(1'b0, 20'h60005, 8'h00, a0, a1, s, d);
    tests++; if (d !== 8'hFF) begin fails++; $display("FAIL auto_deferred_release: got %h, required FF", d); end
  endtask
`else
  task automatic test_no_auto_release();
    logic a0, a1, s; logic [7:0] d;
    pia_row = 4'd1; step();
    bus_cycle(1'b1, 20'h60005, 8'h7F, a0, a1, s, d); model_write(5, 8'h7F);
    for (int k = 0; k < 10; k++) scan_once();
    step();
    bus_cycle(1'b0, 20'h60005, 8'h00, a0, a1, s, d);
    tests++; if (d !== exp_row(5)) begin fails++; $display("FAIL no_auto_release: got %h, required %h", d, exp_row(5)); end
  endtask
`endif

  task automatic test_async_reset();
    logic a0, a1, s; logic [7:0] d;
    bus_cycle(1'b1, 20'h60002, 8'h00, a0, a1, s, d); model_write(2, 8'h00);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 20'h60002;
    step();
    tests++; if (wb_ack !== 1'b1 || wb_rdata !== exp_row(2)) begin
      fails++; $display("FAIL areset_pre: ack=%b data=%h, required 1 %h", wb_ack, wb_rdata, exp_row(2));
    end
    #2 rst = 1'b1;
    #1;
    tests++; if (wb_ack !== 1'b0 || wb_stall !== 1'b0) begin
      fails++; $display("FAIL areset_ack: ack=%b stall=%b, required 0 0", wb_ack, wb_stall);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    step(); rst = 1'b0; model_reset();
    step();
    tests++; if (pia_col !== 8'hFF) begin fails++; $display("FAIL areset_pia: got %h, required FF", pia_col); end
    bus_cycle(1'b0, 20'h60002, 8'h00, a0, a1, s, d);
    tests++; if (a1 !== 1'b1 || d !== 8'hFF) begin
      fails++; $display("FAIL areset_row2: ack=%b data=%h, required 1 FF", a1, d);
    end
  endtask

  initial begin
    rst = 1'b1; wb_addr = '0; wb_wdata = '0; wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; pia_row = 4'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();
    test_reset();
    test_write_read();
    test_discard_unselected();
    test_back_to_back();
    test_random();
`ifdef KBD_AUTO_RELEASE_EN
    test_auto_release();
`else
    test_no_auto_release();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
